// File: rtl/interface_pkg.sv
// interface_pkg: shared fill-state encoding, wrap-4 boundary mask and line geometry
package interface_pkg;
   typedef enum logic [1:0] {IDLE, FILL, DONE} FILL_STATES;
   localparam logic [31:0] WRAP4_BOUNDARY_MASK = 32'hFFFF_FFF0;
   localparam int LINE_WORDS = 4;
endpackage

// File: rtl/line_fill_buffer.sv
// line_fill_buffer: assembles a 4-word cache line from out-of-order bus beats, forwarding the critical word early
module line_fill_buffer import interface_pkg::*; #(
   parameter int LINE_WORDS = 4,
   parameter int WORD_W     = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [31:0]                  miss_addr,
   input  logic                         flush,
   input  logic                         beat_valid,
   input  logic [31:0]                  beat_addr,
   input  logic [WORD_W-1:0]            beat_data,
   output logic                         busy,
   output logic                         crit_valid,
   output logic [WORD_W-1:0]            crit_data,
   output logic                         line_valid,
   output logic [31:0]                  line_addr,
   output logic [LINE_WORDS*WORD_W-1:0] line_data,
   output logic                         err
);
   FILL_STATES state_q, state_d;
   logic [31:0] base_q;
   logic [1:0] crit_idx_q, idx;
   logic [3:0] mask_q, mask_d;
   logic [WORD_W-1:0] words_q [LINE_WORDS];
   logic [WORD_W-1:0] crit_data_q;
   logic crit_sent_q, crit_valid_q, err_q, take, hit, accept, crit_hit;
   logic unused_addr_bits;
   assign unused_addr_bits = ^{miss_addr[1:0], beat_addr[1:0]};
   // Beat qualification and next state; flush outranks any beat in the same cycle
   always_comb begin
      idx      = beat_addr[3:2];
      take     = state_q == FILL && beat_valid && !flush;
      hit      = beat_addr[31:4] == base_q[31:4];
      accept   = take && hit;
      crit_hit = accept && idx == crit_idx_q && !crit_sent_q;
      mask_d   = accept ? mask_q | (4'b1 << idx) : mask_q;
      state_d  = state_q == IDLE ? (start ? FILL : IDLE) :
                 state_q == FILL ? (flush ? IDLE : (&mask_d ? DONE : FILL)) : IDLE;
   end
   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end
   // Line storage, word mask and one-shot critical-word / error pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_q       <= '0;
         crit_idx_q   <= '0;
         mask_q       <= '0;
         crit_sent_q  <= 1'b0;
         crit_valid_q <= 1'b0;
         crit_data_q  <= '0;
         err_q        <= 1'b0;
         for (int k = 0; k < LINE_WORDS; k++) words_q[k] <= '0;
      end else begin
         crit_valid_q <= crit_hit;
         err_q        <= take && !hit;
         if (crit_hit) crit_data_q <= beat_data;
         if (state_q == IDLE && start) begin
            base_q      <= miss_addr & WRAP4_BOUNDARY_MASK;
            crit_idx_q  <= miss_addr[3:2];
            mask_q      <= '0;
            crit_sent_q <= 1'b0;
         end else begin
            mask_q <= mask_d;
            if (accept) words_q[idx] <= beat_data;
            if (crit_hit) crit_sent_q <= 1'b1;
         end
      end
   end
   for (genvar i = 0; i < LINE_WORDS; i++) begin : g_word
      assign line_data[i*WORD_W +: WORD_W] = words_q[i];
   end
   assign busy       = state_q != IDLE;
   assign line_valid = state_q == DONE;
   assign line_addr  = base_q;
   assign crit_valid = crit_valid_q;
   assign crit_data  = crit_data_q;
   assign err        = err_q;
endmodule
